// File: rtl/aqua_vend_multi.sv
// rtl/aqua_vend_multi.sv - multi-volume water vending FSM with change, refund, timeout and BCD amount-due display
// Define AQUA_COIN20_EN to accept coin code 11 as a 20 Rs coin; otherwise code 11 behaves like no coin.
module aqua_vend_multi #(
    parameter int NUM_PROD    = 4,
    parameter int PRICE_BASE  = 15,
    parameter int CREDIT_W    = 7,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_PROD-1:0] sel,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic [NUM_PROD-1:0] dispense,
    output logic [CREDIT_W-1:0] change,
    output logic                change_vld,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          disp_tens,
    output logic [3:0]          disp_ones
);

    localparam int IW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_DISPENSE = 2'd2;
    localparam logic [1:0] S_REFUND   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [NUM_PROD-1:0] dispense_q, dispense_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                change_vld_q, change_vld_d;

    logic [CREDIT_W-1:0] coin_val;
    logic                coin_hit;
    logic [IW-1:0]       sel_idx;
    logic [CREDIT_W-1:0] sel_price;
    logic                sel_ok;
    logic [CREDIT_W-1:0] next_credit;
    logic [CREDIT_W-1:0] due;
    logic [CREDIT_W-1:0] tens_w;
    logic [CREDIT_W-1:0] ones_w;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = CREDIT_W'(5);
            2'b10:   coin_val = CREDIT_W'(10);
`ifdef AQUA_COIN20_EN
            2'b11:   coin_val = CREDIT_W'(20);
`else
            2'b11:   coin_val = '0;
`endif
            default: coin_val = '0;
        endcase
    end

    assign coin_hit    = |coin_val;
    assign next_credit = credit_q + coin_val;
    assign sel_ok      = $onehot(sel);

    always_comb begin
        sel_idx   = '0;
        sel_price = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (sel[i]) begin
                sel_idx   = IW'(i);
                sel_price = CREDIT_W'(PRICE_BASE * (i + 1));
            end
        end
    end

    // Output pulses are computed on the transition so they appear registered in the following cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        price_d      = price_q;
        credit_d     = credit_q;
        tmo_d        = tmo_q;
        dispense_d   = '0;
        change_d     = '0;
        change_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                credit_d = '0;
                if (sel_ok) begin
                    idx_d    = sel_idx;
                    price_d  = sel_price;
                    credit_d = coin_val;
                    tmo_d    = '0;
                    state_d  = S_COLLECT;
                end else if (coin_hit) begin
                    change_d     = coin_val;
                    change_vld_d = 1'b1;
                end
            end
            S_COLLECT: begin
                tmo_d = coin_hit ? '0 : tmo_q + TW'(1);
                if (cancel) begin
                    credit_d     = next_credit;
                    change_d     = next_credit;
                    change_vld_d = |next_credit;
                    state_d      = S_REFUND;
                end else if (next_credit >= price_q) begin
                    credit_d     = next_credit;
                    dispense_d   = NUM_PROD'(1) << idx_q;
                    change_d     = next_credit - price_q;
                    change_vld_d = (next_credit != price_q);
                    state_d      = S_DISPENSE;
                end else if (!coin_hit && tmo_q == TMO_LAST) begin
                    change_d     = credit_q;
                    change_vld_d = |credit_q;
                    state_d      = S_REFUND;
                end else begin
                    credit_d = next_credit;
                end
            end
            default: begin
                credit_d = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            price_q      <= '0;
            credit_q     <= '0;
            tmo_q        <= '0;
            dispense_q   <= '0;
            change_q     <= '0;
            change_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            price_q      <= price_d;
            credit_q     <= credit_d;
            tmo_q        <= tmo_d;
            dispense_q   <= dispense_d;
            change_q     <= change_d;
            change_vld_q <= change_vld_d;
        end
    end

    // Amount due is clamped at zero (overpaid on entry) and saturated at two BCD digits.
    always_comb begin
        due = '0;
        if (state_q == S_COLLECT && price_q > credit_q) begin
            due = price_q - credit_q;
        end
        if (due > CREDIT_W'(99)) begin
            due = CREDIT_W'(99);
        end
        tens_w = due / CREDIT_W'(10);
        ones_w = due % CREDIT_W'(10);
    end

    assign dispense   = dispense_q;
    assign change     = change_q;
    assign change_vld = change_vld_q;
    assign busy       = (state_q != S_IDLE);
    assign credit     = credit_q;
    assign disp_tens  = 4'(tens_w);
    assign disp_ones  = 4'(ones_w);

endmodule
